// File: rtl/ascii_load_sched_if.sv
// Bundle of ioctl, UART and ACIA-side signals around the receive scheduler.
interface ascii_load_sched_if;
    logic       load_from;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       busy;
    logic       overflow;

    modport master (
        output load_from, ioctl_download, ioctl_wr, ioctl_data,
        output uart_valid, uart_data, rx_ready,
        input  ioctl_wait, rx_valid, rx_data, busy, overflow
    );

    modport slave (
        input  load_from, ioctl_download, ioctl_wr, ioctl_data,
        input  uart_valid, uart_data, rx_ready,
        output ioctl_wait, rx_valid, rx_data, busy, overflow
    );
endinterface

// File: rtl/ascii_load_sched.sv
// Paced file/UART byte scheduler feeding the ACIA receive path.
// Optional LOAD_NEWLINE_XLATE_EN: file-mode CR LF / lone LF become a single CR.
module ascii_load_sched #(
    parameter int FIFO_AW     = 4,
    parameter int PACE_CYCLES = 48000,
    parameter int LINE_MULT   = 20
) (
    input  logic               clk_sys,
    input  logic               reset,
    ascii_load_sched_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int LONG  = PACE_CYCLES * LINE_MULT;
    localparam int GW    = $clog2(LONG + 1);

    localparam logic [GW-1:0] GAP_SHORT = GW'(PACE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LONG  = GW'(LONG - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH      = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic [GW-1:0]      gap;
    state_t             state;
    logic               lf_q;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               ioctl_wait;
    logic               overflow;

    logic       file_mode;
    logic       flush;
    logic       raw_push;
    logic [7:0] raw_data;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic       wr;
    logic       pop;

    assign file_mode = ~bus.load_from;
    assign flush     = bus.load_from ^ lf_q;
    assign raw_push  = file_mode ? (bus.ioctl_download & bus.ioctl_wr)
                                 : bus.uart_valid;
    assign raw_data  = file_mode ? bus.ioctl_data : bus.uart_data;

`ifdef LOAD_NEWLINE_XLATE_EN
    logic last_cr;

    always_comb begin
        push      = raw_push;
        push_data = raw_data;
        if (file_mode && raw_data == 8'h0A) begin
            push      = raw_push & ~last_cr;
            push_data = 8'h0D;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush)
            last_cr <= 1'b0;
        else if (raw_push && file_mode)
            last_cr <= (raw_data == 8'h0D);
    end
`else
    assign push      = raw_push;
    assign push_data = raw_data;
`endif

    // Full is judged on the pre-pop count, so push+pop on full drops.
    assign full = (count == FULL);
    assign wr   = push & ~full;
    assign pop  = (state == IDLE) && (count != '0) && (gap == '0);

    always_comb begin
        count_next = count;
        if (wr && !pop)
            count_next = count + CW'(1);
        else if (!wr && pop)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (wr && !reset && !flush)
            mem[wptr] <= push_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lf_q       <= bus.load_from;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            gap        <= '0;
            state      <= IDLE;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            lf_q <= bus.load_from;
            if (flush) begin
                wptr       <= '0;
                rptr       <= '0;
                count      <= '0;
                gap        <= '0;
                state      <= IDLE;
                rx_valid   <= 1'b0;
                ioctl_wait <= 1'b0;
            end else begin
                if (wr)
                    wptr <= wptr + FIFO_AW'(1);
                if (push && full)
                    overflow <= 1'b1;
                count      <= count_next;
                ioctl_wait <= file_mode && (count_next >= HIGH);
                unique case (state)
                    IDLE: begin
                        if (pop) begin
                            rx_data  <= mem[rptr];
                            rptr     <= rptr + FIFO_AW'(1);
                            rx_valid <= 1'b1;
                            state    <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (bus.rx_ready) begin
                            rx_valid <= 1'b0;
                            state    <= GAP;
                            if (!file_mode)
                                gap <= '0;
                            else if (rx_data == 8'h0D)
                                gap <= GAP_LONG;
                            else
                                gap <= GAP_SHORT;
                        end
                    end
                    GAP: begin
                        if (gap == '0)
                            state <= IDLE;
                        else
                            gap <= gap - GW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_valid   = rx_valid;
    assign bus.rx_data    = rx_data;
    assign bus.ioctl_wait = ioctl_wait;
    assign bus.overflow   = overflow;
    assign bus.busy       = (count != '0) || (state != IDLE);
endmodule

// File: tb/tb_ascii_load_sched.sv
// Bench for ascii_load_sched: queue-based timing model plus directed literal checks.
module tb_ascii_load_sched;
    localparam int P  = 8;
    localparam int LM = 4;
    localparam int D  = 16;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   nprint;

    ascii_load_sched_if bus();

    ascii_load_sched #(
        .FIFO_AW(4),
        .PACE_CYCLES(P),
        .LINE_MULT(LM)
    ) dut (
        .clk_sys(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: FIFO as a queue, pacing as "earliest idle cycle".
    logic [7:0] m_q[$];
    bit         m_valid;
    logic [7:0] m_data;
    bit         m_wait;
    bit         m_ovf;
    bit         m_lf;
    bit         m_lastcr;
    int         m_idle_from;
    int         cyc;
    bit         armed;

    task automatic model_step();
        int         sz0;
        bit         file;
        bit         push;
        logic [7:0] d;
        file = !bus.load_from;
        if (reset) begin
            m_q.delete();
            m_valid     = 0;
            m_data      = 8'h00;
            m_wait      = 0;
            m_ovf       = 0;
            m_lastcr    = 0;
            m_idle_from = cyc + 1;
            armed       = 1;
        end else if (bus.load_from != m_lf) begin
            m_q.delete();
            m_valid     = 0;
            m_wait      = 0;
            m_lastcr    = 0;
            m_idle_from = cyc + 1;
        end else begin
            sz0  = m_q.size();
            push = file ? (bus.ioctl_download && bus.ioctl_wr)
                        : bus.uart_valid;
            d    = file ? bus.ioctl_data : bus.uart_data;
`ifdef LOAD_NEWLINE_XLATE_EN
            if (file && push) begin
                if (d == 8'h0A) begin
                    if (m_lastcr) push = 0;
                    d        = 8'h0D;
                    m_lastcr = 0;
                end else begin
                    m_lastcr = (d == 8'h0D);
                end
            end
`endif
            if (!m_valid && cyc >= m_idle_from && sz0 > 0) begin
                m_data  = m_q.pop_front();
                m_valid = 1;
            end else if (m_valid && bus.rx_ready) begin
                m_valid = 0;
                if (!file)
                    m_idle_from = cyc + 2;
                else if (m_data == 8'h0D)
                    m_idle_from = cyc + 1 + P * LM;
                else
                    m_idle_from = cyc + 1 + P;
            end
            if (push) begin
                if (sz0 >= D) m_ovf = 1;
                else m_q.push_back(d);
            end
            m_wait = file && (m_q.size() >= D - 2);
        end
        m_lf = bus.load_from;
        cyc++;
    endtask

    always @(posedge clk) model_step();

    task automatic miss(string n, int act, int exp);
        miscompares++;
        if (nprint < 40)
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, act, exp);
        nprint++;
    endtask

    always @(negedge clk) begin
        bit eb;
        if (armed) begin
            vectors++;
            eb = (m_q.size() != 0) || m_valid || (cyc < m_idle_from);
            if (bus.rx_valid !== m_valid) miss("rx_valid", bus.rx_valid, m_valid);
            if (m_valid && bus.rx_data !== m_data)
                miss("rx_data", bus.rx_data, m_data);
            if (bus.ioctl_wait !== m_wait)
                miss("ioctl_wait", bus.ioctl_wait, m_wait);
            if (bus.busy !== eb) miss("busy", bus.busy, eb);
            if (bus.overflow !== m_ovf) miss("overflow", bus.overflow, m_ovf);
        end
    end

    task automatic chk(string n, int act, int exp);
        vectors++;
        if (act !== exp) miss(n, act, exp);
    endtask

    task automatic idle_in();
        bus.ioctl_wr   = 0;
        bus.ioctl_data = 8'h00;
        bus.uart_valid = 0;
        bus.uart_data  = 8'h00;
    endtask

    task automatic do_reset(bit lf);
        idle_in();
        bus.load_from = lf;
        bus.rx_ready  = 0;
        reset         = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic push_file(logic [7:0] b);
        @(negedge clk);
        bus.ioctl_download = 1;
        bus.ioctl_wr       = 1;
        bus.ioctl_data     = b;
    endtask

    task automatic wait_valid(string n, int budget, output int k);
        k = 0;
        do begin
            @(negedge clk);
            idle_in();
            k++;
        end while (!bus.rx_valid && k < budget);
        if (!bus.rx_valid) begin
            vectors++;
            miss({n, "_timeout"}, k, budget);
        end
    endtask

    task automatic drain(int budget, int want, ref logic [7:0] got[$]);
        for (int c = 0; c < budget && got.size() < want; c++) begin
            @(negedge clk);
            idle_in();
            bus.rx_ready = 1;
            if (bus.rx_valid) got.push_back(bus.rx_data);
        end
    endtask

    initial begin
        int         k;
        int         sent;
        int         bad;
        bit         seen;
        logic [7:0] got[$];
        logic [7:0] exp_q[$];
        logic [7:0] b;

        vectors = 0;
        miscompares = 0;
        nprint = 0;
        cyc = 0;
        armed = 0;
        m_idle_from = 0;
        bus.load_from = 0;
        bus.ioctl_download = 0;
        bus.rx_ready = 0;
        idle_in();
        reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_wait", bus.ioctl_wait, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset = 0;

        // 1: latency and pacing
        do_reset(0);
        bus.rx_ready = 1;
        push_file(8'h41);
        @(negedge clk);
        idle_in();
        chk("t1_valid_n1", bus.rx_valid, 0);
        @(negedge clk);
        chk("t1_valid_n2", bus.rx_valid, 1);
        chk("t1_data", bus.rx_data, 8'h41);
        bus.ioctl_wr = 1;
        bus.ioctl_data = 8'h42;
        wait_valid("t1", 100, k);
        chk("t1_gap", k, P + 2);
        chk("t1_data2", bus.rx_data, 8'h42);

        // 2: long gap after CR, LF handling
        do_reset(0);
        bus.rx_ready = 1;
        push_file(8'h0D);
        push_file(8'h41);
        @(negedge clk);
        idle_in();
        chk("t2_cr", bus.rx_data, 8'h0D);
        wait_valid("t2a", 200, k);
        chk("t2_cr_gap", k, P * LM + 2);
        chk("t2_a", bus.rx_data, 8'h41);
        bus.ioctl_wr = 1;
        bus.ioctl_data = 8'h0A;
        wait_valid("t2b", 200, k);
        chk("t2_lf_gap", k, P + 2);
`ifdef LOAD_NEWLINE_XLATE_EN
        chk("t2_lf", bus.rx_data, 8'h0D);
`else
        chk("t2_lf", bus.rx_data, 8'h0A);
`endif

        // 3: host honours ioctl_wait
        do_reset(0);
        bus.ioctl_download = 1;
        sent = 0;
        seen = 0;
        got.delete();
        for (int c = 0; c < 1500 && got.size() < 20; c++) begin
            @(negedge clk);
            bus.rx_ready = (c >= 30);
            if (bus.rx_valid && bus.rx_ready) got.push_back(bus.rx_data);
            if (bus.ioctl_wait && !seen) begin
                seen = 1;
                chk("t3_wait_at", sent, 15);
            end
            if (sent < 20 && !bus.ioctl_wait) begin
                bus.ioctl_wr = 1;
                bus.ioctl_data = 8'h60 + 8'(sent);
                sent++;
            end else begin
                bus.ioctl_wr = 0;
            end
        end
        idle_in();
        chk("t3_seen_wait", seen, 1);
        chk("t3_count", got.size(), 20);
        bad = 0;
        foreach (got[i]) if (got[i] !== 8'h60 + 8'(i)) bad++;
        chk("t3_order", bad, 0);
        chk("t3_overflow", bus.overflow, 0);

        // 4: host ignores wait, drop on full
        do_reset(0);
        push_file(8'h30);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        for (int i = 1; i <= 17; i++) push_file(8'h30 + 8'(i));
        @(negedge clk);
        idle_in();
        chk("t4_overflow", bus.overflow, 1);
        chk("t4_wait", bus.ioctl_wait, 1);
        got.delete();
        drain(800, 18, got);
        chk("t4_count", got.size(), 17);
        chk("t4_last", got[got.size()-1], 8'h40);
        chk("t4_sticky", bus.overflow, 1);

        // 5: UART mode, no pacing, ioctl ignored
        do_reset(1);
        bus.rx_ready = 1;
        bus.ioctl_download = 1;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                if (bus.rx_valid) got.push_back(bus.rx_data);
                b = 8'($urandom);
                bus.uart_valid = (s == 0);
                bus.uart_data = b;
                bus.ioctl_wr = 1;
                bus.ioctl_data = 8'($urandom);
                if (s == 0) exp_q.push_back(b);
                if (bus.ioctl_wait) chk("t5_wait", bus.ioctl_wait, 0);
            end
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle_in();
            if (bus.rx_valid) got.push_back(bus.rx_data);
        end
        chk("t5_count", got.size(), 10);
        bad = 0;
        foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) bad++;
        chk("t5_order", bad, 0);
        chk("t5_wait_end", bus.ioctl_wait, 0);

        // 6: mode switch flush, reset mid-GAP
        do_reset(0);
        for (int i = 0; i < 6; i++) push_file(8'h50 + 8'(i));
        @(negedge clk);
        idle_in();
        @(negedge clk);
        chk("t6_valid_before", bus.rx_valid, 1);
        bus.load_from = 1;
        @(negedge clk);
        chk("t6_valid_after", bus.rx_valid, 0);
        chk("t6_busy_after", bus.busy, 0);
        bus.load_from = 0;
        repeat (2) @(negedge clk);
        bus.rx_ready = 1;
        push_file(8'h55);
        wait_valid("t6", 20, k);
        repeat (3) @(negedge clk);
        chk("t6_busy_gap", bus.busy, 1);
        reset = 1;
        bus.ioctl_wr = 1;
        bus.ioctl_data = 8'h66;
        @(negedge clk);
        chk("t6_rst_valid", bus.rx_valid, 0);
        chk("t6_rst_data", bus.rx_data, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_wait", bus.ioctl_wait, 0);
        chk("t6_rst_ovf", bus.overflow, 0);
        reset = 0;
        idle_in();

        // Random traffic against the model
        do_reset(0);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 599) == 0) bus.load_from = ~bus.load_from;
            bus.ioctl_download = ($urandom_range(0, 9) != 0);
            bus.ioctl_wr = ($urandom_range(0, 9) < 4) &&
                           (!bus.ioctl_wait || $urandom_range(0, 9) < 2);
            case ($urandom_range(0, 5))
                0: bus.ioctl_data = 8'h0D;
                1: bus.ioctl_data = 8'h0A;
                default: bus.ioctl_data = 8'($urandom_range(32, 126));
            endcase
            bus.uart_valid = ($urandom_range(0, 4) == 0);
            bus.uart_data = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
            bus.rx_ready = ($urandom_range(0, 9) < 6);
        end
        reset = 0;
        idle_in();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
